// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register, one-entry skid buffer,
// branch/jump redirect with in-flight response discard, and halt parking.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_b,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        halted,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_if_instr, w_if_instr_nxt;
    logic [31:0] r_if_pc4, w_if_pc4_nxt;
    logic        r_if_valid, w_if_valid_nxt;
    logic        r_skid_valid, w_skid_valid_nxt;
    logic [31:0] r_skid_instr, w_skid_instr_nxt;
    logic [31:0] r_skid_pc4, w_skid_pc4_nxt;
    logic        r_discard, w_discard_nxt;
    logic [31:0] r_target, w_target_nxt;

    logic        w_req;
    logic        w_fire;
    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;

    // Handshake: a word transfers in any cycle where imem_req && imem_ready;
    // once imem_req is raised, imem_addr stays fixed until that transfer happens.
    assign w_req      = (r_state != S_HALT) && !r_skid_valid;
    assign w_fire     = w_req && imem_ready;
    assign w_redirect = branch_taken || jump;
    assign w_pc_plus4 = r_pc + 32'd4;
    // Branch is the older instruction, so it wins over a jump in IF/ID.
    assign w_target   = branch_taken ? branch_target
                                     : {r_if_pc4[31:28], r_if_instr[25:0], 2'b00};

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_if_instr_nxt   = r_if_instr;
        w_if_pc4_nxt     = r_if_pc4;
        w_if_valid_nxt   = r_if_valid;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_instr_nxt = r_skid_instr;
        w_skid_pc4_nxt   = r_skid_pc4;
        w_discard_nxt    = r_discard;
        w_target_nxt     = r_target;

        if (w_redirect) begin
            w_if_instr_nxt   = 32'd0;
            w_if_valid_nxt   = 1'b0;
            w_skid_valid_nxt = 1'b0;
            // A request already presented must complete at its address; its
            // data is thrown away and the target is issued afterwards.
            if (w_req && !imem_ready) begin
                w_discard_nxt = 1'b1;
                w_target_nxt  = w_target;
                w_state_nxt   = S_WAIT;
            end else begin
                w_pc_nxt      = w_target;
                w_discard_nxt = 1'b0;
                w_state_nxt   = S_RUN;
            end
        end else if (r_discard) begin
            if (stall_b) begin
                w_if_instr_nxt = 32'd0;
                w_if_valid_nxt = 1'b0;
            end
            if (w_fire) begin
                w_discard_nxt = 1'b0;
                w_pc_nxt      = r_target;
                w_state_nxt   = S_RUN;
            end
        end else if (w_fire) begin
            w_pc_nxt    = w_pc_plus4;
            w_state_nxt = (imem_rdata[31:26] == 6'h3f) ? S_HALT : S_RUN;
            if (stall_b) begin
                w_if_instr_nxt = imem_rdata;
                w_if_pc4_nxt   = w_pc_plus4;
                w_if_valid_nxt = 1'b1;
            end else begin
                w_skid_valid_nxt = 1'b1;
                w_skid_instr_nxt = imem_rdata;
                w_skid_pc4_nxt   = w_pc_plus4;
            end
        end else begin
            if (w_req) begin
                w_state_nxt = S_WAIT;
            end
            if (stall_b) begin
                if (r_skid_valid) begin
                    w_if_instr_nxt   = r_skid_instr;
                    w_if_pc4_nxt     = r_skid_pc4;
                    w_if_valid_nxt   = 1'b1;
                    w_skid_valid_nxt = 1'b0;
                end else begin
                    w_if_instr_nxt = 32'd0;
                    w_if_valid_nxt = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_RUN;
            r_pc         <= RESET_PC;
            r_if_instr   <= 32'd0;
            r_if_pc4     <= 32'd0;
            r_if_valid   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_instr <= 32'd0;
            r_skid_pc4   <= 32'd0;
            r_discard    <= 1'b0;
            r_target     <= 32'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_if_instr   <= w_if_instr_nxt;
            r_if_pc4     <= w_if_pc4_nxt;
            r_if_valid   <= w_if_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_instr <= w_skid_instr_nxt;
            r_skid_pc4   <= w_skid_pc4_nxt;
            r_discard    <= w_discard_nxt;
            r_target     <= w_target_nxt;
        end
    end

    assign imem_req          = w_req && !rst;
    assign imem_addr         = r_pc;
    assign if_id_instruction = r_if_instr;
    assign if_id_pc_plus4    = r_if_pc4;
    assign if_id_valid       = r_if_valid;
    assign halted            = (r_state == S_HALT);
    assign dbg_state         = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table for streaming/stall, then
// hand-written jump, discard, halt, wrap and reset-mid-fetch sequences.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_b;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        halted;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_instr = 32'd0;

    typedef struct {
        logic        stall_b;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc4;
        logic        pop;
    } vec_t;

    vec_t vecs[13];

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall_b(stall_b),
        .branch_taken(branch_taken), .branch_target(branch_target), .jump(jump),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .if_id_instruction(if_id_instruction),
        .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid),
        .halted(halted), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_003C: rom = 32'h0800_0010;
            32'h0000_0044: rom = 32'h0800_0100;
            32'h0000_0200: rom = 32'hFC00_0000;
            default:       rom = {8'hA5, a[23:0]};
        endcase
    endfunction

    always_comb imem_rdata = rom(imem_addr);

    function automatic vec_t mk(input logic s, input logic r, input logic q,
                                input logic [31:0] a, input logic v,
                                input logic [31:0] p, input logic pp);
        vec_t x;
        x.stall_b = s; x.ready = r; x.exp_req = q; x.exp_addr = a;
        x.exp_valid = v; x.exp_pc4 = p; x.pop = pp;
        return x;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive one cycle from a negedge, check fetch outputs, record the
    // expected word if this cycle should deliver one, then advance.
    task automatic cyc(input logic s, input logic r, input logic b,
                       input logic [31:0] t, input logic j,
                       input logic exp_req, input logic [31:0] exp_addr,
                       input logic push);
        stall_b = s; imem_ready = r; branch_taken = b; branch_target = t; jump = j;
        #1;
        chk32("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        chk32("imem_addr", imem_addr, exp_addr);
        if (push) exp_q.push_back(rom(exp_addr));
        tick();
        branch_taken = 1'b0; jump = 1'b0;
    endtask

    task automatic chk_ifid(input logic exp_valid, input logic [31:0] exp_pc4, input logic pop);
        chk32("if_id_valid", {31'd0, if_id_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            chk32("if_id_pc_plus4", if_id_pc_plus4, exp_pc4);
            if (pop) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard_empty got word %h want none", if_id_instruction);
                end else begin
                    last_instr = exp_q.pop_front();
                end
            end
            chk32("if_id_instruction", if_id_instruction, last_instr);
        end else begin
            chk32("if_id_bubble_instr", if_id_instruction, 32'd0);
        end
    endtask

    initial begin
        vecs[0]  = mk(1'b1, 1'b1, 1'b1, 32'h00, 1'b1, 32'h04, 1'b1);
        vecs[1]  = mk(1'b1, 1'b1, 1'b1, 32'h04, 1'b1, 32'h08, 1'b1);
        vecs[2]  = mk(1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0C, 1'b1);
        vecs[3]  = mk(1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h0C, 1'b0);
        vecs[4]  = mk(1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h0C, 1'b0);
        vecs[5]  = mk(1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h0C, 1'b0);
        vecs[6]  = mk(1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h10, 1'b1);
        vecs[7]  = mk(1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h14, 1'b1);
        vecs[8]  = mk(1'b1, 1'b0, 1'b1, 32'h14, 1'b0, 32'h00, 1'b0);
        vecs[9]  = mk(1'b1, 1'b0, 1'b1, 32'h14, 1'b0, 32'h00, 1'b0);
        vecs[10] = mk(1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h18, 1'b1);
        vecs[11] = mk(1'b0, 1'b0, 1'b1, 32'h18, 1'b1, 32'h18, 1'b0);
        vecs[12] = mk(1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h1C, 1'b1);

        rst = 1'b1; stall_b = 1'b1; branch_taken = 1'b0; branch_target = 32'd0;
        jump = 1'b0; imem_ready = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk32("rst_req", {31'd0, imem_req}, 32'd0);
        chk32("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk32("rst_instr", if_id_instruction, 32'd0);
        chk32("rst_pc4", if_id_pc_plus4, 32'd0);
        chk32("rst_halted", {31'd0, halted}, 32'd0);
        chk32("rst_state", {30'd0, dbg_state}, 32'd0);
        rst = 1'b0;

        // Streaming, skid stall, ready gaps
        for (int i = 0; i < 13; i++) begin
            cyc(vecs[i].stall_b, vecs[i].ready, 1'b0, 32'd0, 1'b0,
                vecs[i].exp_req, vecs[i].exp_addr,
                vecs[i].exp_req && vecs[i].ready);
            chk_ifid(vecs[i].exp_valid, vecs[i].exp_pc4, vecs[i].pop);
        end

        // Jump from IF/ID: j at 0x3C targets 0x40, then j at 0x44 targets 0x400
        cyc(1'b1, 1'b1, 1'b1, 32'h3C, 1'b0, 1'b1, 32'h1C, 1'b0); chk_ifid(1'b0, 32'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h3C, 1'b1); chk_ifid(1'b1, 32'h40, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h40, 1'b0); chk_ifid(1'b0, 32'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h40, 1'b1); chk_ifid(1'b1, 32'h44, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h44, 1'b1); chk_ifid(1'b1, 32'h48, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h48, 1'b0); chk_ifid(1'b0, 32'd0, 1'b0);

        // Branch while a request is outstanding: 0x20 held, its word dropped
        cyc(1'b1, 1'b1, 1'b1, 32'h20,  1'b0, 1'b1, 32'h400, 1'b0); chk_ifid(1'b0, 32'd0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h20, 1'b0);
        chk32("wait_state", {30'd0, dbg_state}, 32'd1);
        cyc(1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 32'h20, 1'b0); chk_ifid(1'b0, 32'd0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h20, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h20, 1'b0); chk_ifid(1'b0, 32'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h100, 1'b1); chk_ifid(1'b1, 32'h104, 1'b1);

        // Halt at 0x200, then exit by branch with stall_b=0 (redirect wins)
        cyc(1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 1'b1, 32'h104, 1'b0); chk_ifid(1'b0, 32'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h200, 1'b1); chk_ifid(1'b1, 32'h204, 1'b1);
        chk32("halted_set", {31'd0, halted}, 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h204, 1'b0); chk_ifid(1'b0, 32'd0, 1'b0);
        chk32("halted_hold", {31'd0, halted}, 32'd1);
        cyc(1'b0, 1'b1, 1'b1, 32'h80,  1'b0, 1'b0, 32'h204, 1'b0); chk_ifid(1'b0, 32'd0, 1'b0);
        chk32("halted_clear", {31'd0, halted}, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h80, 1'b1); chk_ifid(1'b1, 32'h84, 1'b1);

        // PC+4 wraps to zero
        cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h84, 1'b0); chk_ifid(1'b0, 32'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1); chk_ifid(1'b1, 32'h0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1); chk_ifid(1'b1, 32'h4, 1'b1);

        // Reset during WAIT at 0x4; late ready while in reset is ignored
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h4, 1'b0); chk_ifid(1'b0, 32'd0, 1'b0);
        chk32("rst2_pc4", if_id_pc_plus4, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0); chk_ifid(1'b0, 32'd0, 1'b0);
        chk32("rst2_state", {30'd0, dbg_state}, 32'd0);
        rst = 1'b0;
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1); chk_ifid(1'b1, 32'h4, 1'b1);

        chk32("scoreboard_leftover", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
